// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and FSM states.
package sseg_pkg;

  localparam logic [6:0] SSEG_OFF = 7'b0000000;

  // Segment order is {a,b,c,d,e,f,g}; segments are active-high.
  localparam logic [6:0] SSEG_D0 = 7'b1111110;
  localparam logic [6:0] SSEG_D1 = 7'b0110000;
  localparam logic [6:0] SSEG_D2 = 7'b1101101;
  localparam logic [6:0] SSEG_D3 = 7'b1111001;
  localparam logic [6:0] SSEG_D4 = 7'b0110011;
  localparam logic [6:0] SSEG_D5 = 7'b1011011;
  localparam logic [6:0] SSEG_D6 = 7'b1011111;
  localparam logic [6:0] SSEG_D7 = 7'b1110000;
  localparam logic [6:0] SSEG_D8 = 7'b1111111;
  localparam logic [6:0] SSEG_D9 = 7'b1111011;

  typedef enum logic {BLANK, SCAN} state_e;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to seven-segment decoder. Codes 10..15 decode to all-off.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    unique case (bcd_i)
      4'd0:    seg_o = SSEG_D0;
      4'd1:    seg_o = SSEG_D1;
      4'd2:    seg_o = SSEG_D2;
      4'd3:    seg_o = SSEG_D3;
      4'd4:    seg_o = SSEG_D4;
      4'd5:    seg_o = SSEG_D5;
      4'd6:    seg_o = SSEG_D6;
      4'd7:    seg_o = SSEG_D7;
      4'd8:    seg_o = SSEG_D8;
      4'd9:    seg_o = SSEG_D9;
      default: seg_o = SSEG_OFF;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a loadable BCD shadow register.
// Define SSEG_LZ_BLANK_EN to blank leading zeros on digits 1..3.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        scan_tick
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [1:0]    idx_q;
  logic [15:0]   shadow_q;
  logic [3:0]    an_q;
  logic [6:0]    sseg_q;

  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  assign scan_tick = (div_q == DIV_LAST);
  assign digit     = shadow_q[{idx_q, 2'b00} +: 4];
  assign an_d      = ~(4'b0001 << idx_q);

  bcd_to_sseg u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  // Overrides sit between the decoder and the output register.
  always_comb begin
    seg_d = dec_seg;
    if (digit > 4'd9) seg_d = SSEG_OFF;
`ifdef SSEG_LZ_BLANK_EN
    unique case (idx_q)
      2'd3:    if (shadow_q[15:12] == 4'd0) seg_d = SSEG_OFF;
      2'd2:    if (shadow_q[15:8]  == 8'd0) seg_d = SSEG_OFF;
      2'd1:    if (shadow_q[15:4]  == 12'd0) seg_d = SSEG_OFF;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BLANK;
      div_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'b1111;
      sseg_q   <= SSEG_OFF;
    end else begin
      div_q <= scan_tick ? '0 : div_q + 1'b1;
      if (scan_tick) idx_q <= idx_q + 2'd1;
      if (load) shadow_q <= bcd_in;
      // Outputs reflect the pre-edge idx/shadow, giving one cycle of latency.
      unique case (state_q)
        BLANK: begin
          an_q   <= 4'b1111;
          sseg_q <= SSEG_OFF;
          if (load) state_q <= SCAN;
        end
        SCAN: begin
          an_q   <= an_d;
          sseg_q <= seg_d;
        end
        default: state_q <= BLANK;
      endcase
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver at REFRESH_DIV=4: cycle-level reference model plus literal spot checks.
module tb_sseg_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        scan_tick;

  int errors = 0;
  int checks = 0;

  sseg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .load      (load),
    .an        (an),
    .sseg      (sseg),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG_TAB [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: time since reset drives divider phase and digit index.
  int          m_cnt   = 0;
  logic [15:0] m_sh    = 16'h0;
  bit          m_scan  = 1'b0;
  bit          m_valid = 1'b0;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [6:0] exp_digit(input logic [15:0] sh, input int k);
    logic [3:0] d;
    d = sh[k*4 +: 4];
    if (d > 4'd9) return 7'b0000000;
`ifdef SSEG_LZ_BLANK_EN
    if (k > 0 && (sh >> (4*k)) == 16'h0) return 7'b0000000;
`endif
    return SEG_TAB[d];
  endfunction

  always @(posedge clk) begin
    int ix;
    if (rst) begin
      m_an = 4'b1111; m_seg = 7'b0; m_cnt = 0; m_sh = 16'h0; m_scan = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_scan) begin
        ix    = (m_cnt / DIV) % 4;
        m_an  = ~(4'b0001 << ix);
        m_seg = exp_digit(m_sh, ix);
      end else begin
        m_an = 4'b1111; m_seg = 7'b0;
      end
      m_cnt++;
      if (load) begin m_sh = bcd_in; m_scan = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (an !== m_an || sseg !== m_seg || scan_tick !== ((m_cnt % DIV) == DIV-1)) begin
        errors++;
        $display("FAIL model cnt=%0d: got an=%b sseg=%b tick=%b, want an=%b sseg=%b tick=%b",
                 m_cnt, an, sseg, scan_tick, m_an, m_seg, ((m_cnt % DIV) == DIV-1));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {tick,an,sseg}=%b want %b", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", {scan_tick, an, sseg}, {1'b0, 4'b1111, 7'b0});
    repeat (40) tick();                                             // cnt=40
    chk("blank_idle", {1'b0, an, sseg}, {1'b0, 4'b1111, 7'b0});

    load = 1'b1; bcd_in = 16'h1234; tick(); load = 1'b0; bcd_in = 16'hFFFF;   // cnt=41
    tick();                                                         // shows cnt41: idx2
    chk("1234_d2", {1'b0, an, sseg}, {1'b0, 4'b1011, 7'b1101101});
    repeat (3) tick();                                              // shows cnt44: idx3
    chk("1234_d3", {1'b0, an, sseg}, {1'b0, 4'b0111, 7'b0110000});
    repeat (4) tick();                                              // shows cnt48: idx0
    chk("1234_d0", {1'b0, an, sseg}, {1'b0, 4'b1110, 7'b0110011});
    repeat (4) tick();                                              // shows cnt52: idx1
    chk("1234_d1", {1'b0, an, sseg}, {1'b0, 4'b1101, 7'b1111001});

    load = 1'b1; bcd_in = 16'h00A7; tick(); load = 1'b0;            // cnt=54
    tick();                                                         // shows cnt54: idx1 = A
    chk("00A7_invalid", {1'b0, an, sseg}, {1'b0, 4'b1101, 7'b0000000});
    repeat (15) tick();

    load = 1'b1; bcd_in = 16'h0005; tick(); load = 1'b0;            // cnt=71
    repeat (16) tick();                                             // cnt=87

    repeat (8) if (m_cnt % DIV != DIV-1) tick();
    chk("tick_before_load", {scan_tick, 11'h0}, {1'b1, 11'h0});
    load = 1'b1; bcd_in = 16'h9876; tick(); load = 1'b0;            // cnt=88, idx becomes 2
    tick();
    chk("load_on_tick", {1'b0, an, sseg}, {1'b0, 4'b1011, 7'b1111111});
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midscan_reset", {scan_tick, an, sseg}, {1'b0, 4'b1111, 7'b0});

    rst = 1'b1; load = 1'b1; bcd_in = 16'h1111; tick();
    rst = 1'b0; load = 1'b0;
    tick(); tick();
    chk("rst_over_load", {1'b0, an, sseg}, {1'b0, 4'b1111, 7'b0});
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
